// File: rtl/exe_alu_stage.sv
// exe_alu_stage
//   Execute stage of the pipeline. Val1 (Rn) and the generated Val2 go
//   through the ALU. The result, the control bits, the destination and the
//   store data are registered into the EXE/MEM pipeline register. The stage
//   also holds the NZCV status register.
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   freeze       hazard stall: pipeline register and status hold
//   flush        squash the instruction in EXE (clears wb/mem enables)
//   val1         Rn value
//   val2         Val2 generator output
//   exe_cmd      ALU operation
//   s_bit        update status when 1
//   wb_en_in     write-back enable
//   mem_r_en_in  load enable
//   mem_w_en_in  store enable
//   dest_in      destination register index
//   val_rm_in    store data
//   alu_res      registered ALU result / memory address
//   wb_en        registered write-back enable
//   mem_r_en     registered load enable
//   mem_w_en     registered store enable
//   dest         registered destination
//   st_val       registered store data
//   status       NZCV register {N,Z,C,V}
module exe_alu_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic [DATA_W-1:0] val1,
  input  logic [DATA_W-1:0] val2,
  input  logic [3:0]        exe_cmd,
  input  logic              s_bit,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [REG_W-1:0]  dest_in,
  input  logic [DATA_W-1:0] val_rm_in,
  output logic [DATA_W-1:0] alu_res,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic [REG_W-1:0]  dest,
  output logic [DATA_W-1:0] st_val,
  output logic [3:0]        status
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [DATA_W-1:0] alu_res_q, st_val_q;
  logic [REG_W-1:0]  dest_q;
  logic              wb_en_q, mem_r_en_q, mem_w_en_q;
  logic [3:0]        status_q;

  logic [DATA_W-1:0] res_d;
  logic [3:0]        status_d;
  logic [DATA_W-1:0] add_b;
  logic              add_cin;
  logic              is_arith;
  logic [DATA_W:0]   sum;
  logic              carry_q;

  assign carry_q = status_q[1];

  // Subtraction runs through the same adder as val1 + ~val2 + cin, so the
  // carry out reads as "no borrow" and overflow uses one rule for both.
  always_comb begin
    add_b    = val2;
    add_cin  = 1'b0;
    is_arith = 1'b0;
    case (exe_cmd)
      CMD_ADD: begin add_b = val2;  add_cin = 1'b0;    is_arith = 1'b1; end
      CMD_ADC: begin add_b = val2;  add_cin = carry_q; is_arith = 1'b1; end
      CMD_SUB: begin add_b = ~val2; add_cin = 1'b1;    is_arith = 1'b1; end
      CMD_SBC: begin add_b = ~val2; add_cin = carry_q; is_arith = 1'b1; end
      default: ;
    endcase
  end

  assign sum = {1'b0, val1} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};

  always_comb begin
    res_d = '0;
    case (exe_cmd)
      CMD_MOV: res_d = val2;
      CMD_MVN: res_d = ~val2;
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: res_d = sum[DATA_W-1:0];
      CMD_AND: res_d = val1 & val2;
      CMD_ORR: res_d = val1 | val2;
      CMD_EOR: res_d = val1 ^ val2;
      default: res_d = '0;
    endcase
  end

  always_comb begin
    status_d    = status_q;
    status_d[3] = res_d[DATA_W-1];
    status_d[2] = (res_d == '0);
    if (is_arith) begin
      status_d[1] = sum[DATA_W];
      status_d[0] = (val1[DATA_W-1] == add_b[DATA_W-1]) &&
                    (res_d[DATA_W-1] != val1[DATA_W-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      status_q   <= '0;
    end else if (flush) begin
      // Squash only the side-effecting enables; data fields simply hold.
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
    end else if (!freeze) begin
      alu_res_q  <= res_d;
      st_val_q   <= val_rm_in;
      dest_q     <= dest_in;
      wb_en_q    <= wb_en_in;
      mem_r_en_q <= mem_r_en_in;
      mem_w_en_q <= mem_w_en_in;
      if (s_bit) status_q <= status_d;
    end
  end

  assign alu_res  = alu_res_q;
  assign st_val   = st_val_q;
  assign dest     = dest_q;
  assign wb_en    = wb_en_q;
  assign mem_r_en = mem_r_en_q;
  assign mem_w_en = mem_w_en_q;
  assign status   = status_q;

endmodule
